sdram_cmd_arbiter: RTL and testbench
====================================

// Module: sdram_cmd_arbiter
// PURPOSE
//  Parametrised successor of the hard-wired SDRAM command mux in the RISC5 top.
//  Arbitrates NCH requesters onto one SDRAM_16bit sys_CMD/sys_ADDR port, with
//  fixed-priority or round-robin selection. Ch0 is optionally a video scan
//  channel with an internal, vsync-resynchronised address counter.
//  Tracks data-phase ownership (generalised crw) and flags ack timeouts.
//  Sits in the clk_sdr domain between cache_controller, vqueue and SDRAM_16bit.
// PARAMETERS
//  NCH          3      number of requesters; ch0 highest priority in fixed mode
//  ADDR_W       18     sys_ADDR width
//  RR_MODE      0      0 = fixed priority (lowest index wins); 1 = round robin
//  VID_EN       1      1 = ch0 address from internal counter; ch_addr[0] ignored
//  VID_WORDS    3072   video burst count per frame; counter wraps VID_WORDS-1 -> 0
//  VID_BASE     18'h37FC0  video base address
//  VID_STRIDE   8      address increment per video burst
//  ACK_TMO      255    cycles to wait for ack before abandoning a command
// PORTS
//  clk          in   1            SDRAM-domain clock
//  rst          in   1            asynchronous reset, active high
//  req          in   NCH          level request per channel; held until ack_o
//  ch_cmd       in   2*NCH        per-channel command code (01 wr, 10/11 rd); 00 invalid
//  ch_addr      in   ADDR_W*NCH   per-channel address
//  vid_sync     in   1            frame sync (async to nothing; same clk), rising edge used
//  sys_CMD      out  2            command to SDRAM controller
//  sys_ADDR     out  ADDR_W       address to SDRAM controller
//  sys_cmd_ack  in   2            controller ack; nonzero = command accepted
//  ack_o        out  NCH          one-cycle accept pulse to the granted channel
//  data_owner   out  NCH          one-hot owner of current data phase (valid routing)
//  vid_adr      out  clog2(VID_WORDS)  current video burst index
//  tmo_err      out  1            sticky: an ack timeout occurred; cleared by rst only
// BEHAVIOUR
//  Reset: sys_CMD=00, sys_ADDR=0, ack_o=0, data_owner=0, vid_adr=0, tmo_err=0,
//   rr pointer=0, state=IDLE. All outputs registered.
//  FSM IDLE -> ISSUE -> HOLD -> IDLE.
//   IDLE: if any req with ch_cmd!=00, pick winner; next cycle sys_CMD=ch_cmd[w],
//    sys_ADDR=addr (latched), state ISSUE. Latency req->sys_CMD: 1 cycle.
//   ISSUE: sys_CMD held stable. On sys_cmd_ack!=00: ack_o[w]=1 for 1 cycle,
//    data_owner=onehot(w), sys_CMD=00, -> HOLD. If ACK_TMO cycles pass with ack=00:
//    sys_CMD=00, tmo_err=1, no ack_o, data_owner unchanged, -> HOLD.
//   HOLD: wait sys_cmd_ack==00, then IDLE (no back-to-back issue on a stale ack).
//  Requests with ch_cmd==00 are ignored. Request drop during ISSUE is ignored
//   (command already latched); caller must hold req until ack_o.
//  Fixed mode: lowest index wins. RR mode: search starts at ptr; after ack_o to w,
//   ptr = (w+1) mod NCH; on timeout ptr unchanged.
//  Video (VID_EN=1): ch0 addr = VID_BASE + vid_adr*VID_STRIDE (ADDR_W-bit wrap).
//   vid_adr += 1 on ack_o[0]; VID_WORDS-1 wraps to 0. Rising edge of vid_sync
//   (registered one cycle) sets vid_adr=0; coincident with ack_o[0], sync wins (0).
//   Sync during ISSUE does not alter the latched sys_ADDR.
//  data_owner persists until next ack; downstream gates sys_rd/wr_data_valid with it.
//  rst mid-transaction: everything returns to reset values immediately; controller
//   sees sys_CMD=00 and must tolerate an aborted command.
// STRUCTURE
//  Package sdram_arb_pkg: command codes CMD_NOP/WR/RDV/RD, state enum IDLE/ISSUE/HOLD.
//  One sub-module: arb_pick (combinational priority/round-robin picker, NCH-generic,
//   inputs valid vector + ptr, output one-hot + index). Video counter and timeout
//   counter inline.
// TESTING
//  Fixed mode, req=3'b110 with ch1=01, ch2=11 -> ch1 issued first (sys_CMD=01),
//   ack -> ack_o=3'b010, data_owner=010; then ch2 issued sys_CMD=11.
//  RR mode, all three requesting continuously, ack after 2 cycles each -> grant order
//   0,1,2,0,1,2; no channel starves.
//  Video: 3072 ch0 acks -> vid_adr counts 0..3071 then 0; sys_ADDR = VID_BASE+8*n.
//  vid_sync edge in the same cycle as ack_o[0] at vid_adr=5 -> vid_adr=0 next cycle.
//  No ack for 256 cycles -> sys_CMD=00, tmo_err=1, ack_o stays 0, FSM reaches IDLE
//   once ack=00, and the next request is serviced normally.
//  rst asserted during ISSUE -> sys_CMD=00, ack_o=0, data_owner=0 same cycle (async).

Source files
------------

// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arb_pkg
// Description : Shared command codes and arbiter state encoding for the
//               SDRAM command arbiter and its priority picker.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

  // SDRAM_16bit sys_CMD codes
  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_WR  = 2'b01;
  localparam logic [1:0] CMD_RDV = 2'b10;
  localparam logic [1:0] CMD_RD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb_pick
// Description : Combinational NCH-wide picker. Scans the valid vector starting
//               at i_ptr and wrapping around; the first valid channel wins.
//               Fixed priority is obtained by holding i_ptr at zero.
// Ports       : i_valid  - per-channel request-valid vector
//               i_ptr    - index where the search starts
//               o_grant  - one-hot winner (all zero if nothing valid)
//               o_idx    - binary winner index
//               o_any    - at least one channel valid
// Revision    : 1.0 - initial release
// ============================================================================
module arb_pick #(
  parameter int NCH   = 3,
  parameter int IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0]   i_valid,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NCH-1:0]   o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  int w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = 0;
    for (int k = 0; k < NCH; k++) begin
      // candidate channel = (ptr + k) mod NCH without a divider
      w_cand = int'(i_ptr) + k;
      if (w_cand >= NCH) begin
        w_cand = w_cand - NCH;
      end
      if (!o_any && i_valid[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = IDX_W'(w_cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_cmd_arbiter
// Description : Arbitrates NCH requesters onto the single sys_CMD/sys_ADDR
//               port of SDRAM_16bit. Fixed priority or round robin. Channel 0
//               may be a video scan channel whose address comes from an
//               internal burst counter cleared by the rising edge of vid_sync.
//               Tracks data-phase ownership and flags ack timeouts.
// Ports       : clk, rst              - clock, async active-high reset
//               req/ch_cmd/ch_addr    - per-channel request, command, address
//               vid_sync              - frame sync (rising edge used)
//               sys_CMD/sys_ADDR      - command/address to the controller
//               sys_cmd_ack           - controller accept (nonzero = accepted)
//               ack_o                 - one-cycle accept pulse per channel
//               data_owner            - one-hot owner of the current data phase
//               vid_adr               - current video burst index
//               tmo_err               - sticky ack-timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_cmd_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NCH        = 3,
  parameter int ADDR_W     = 18,
  parameter int RR_MODE    = 0,
  parameter int VID_EN     = 1,
  parameter int VID_WORDS  = 3072,
  parameter int VID_BASE   = 'h37FC0,
  parameter int VID_STRIDE = 8,
  parameter int ACK_TMO    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NCH-1:0]               req,
  input  logic [2*NCH-1:0]             ch_cmd,
  input  logic [ADDR_W*NCH-1:0]        ch_addr,
  input  logic                         vid_sync,
  output logic [1:0]                   sys_CMD,
  output logic [ADDR_W-1:0]            sys_ADDR,
  input  logic [1:0]                   sys_cmd_ack,
  output logic [NCH-1:0]               ack_o,
  output logic [NCH-1:0]               data_owner,
  output logic [$clog2(VID_WORDS)-1:0] vid_adr,
  output logic                         tmo_err
);

  localparam int c_idx_w = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int c_va_w  = $clog2(VID_WORDS);
  localparam int c_tmo_w = $clog2(ACK_TMO + 1);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [c_idx_w-1:0]  r_ptr;
  logic [c_idx_w-1:0]  r_win;
  logic [NCH-1:0]      r_win_oh;
  logic [c_tmo_w-1:0]  r_tmo_cnt;
  logic                r_sync_d;

  logic [NCH-1:0]      w_valid;
  logic [NCH-1:0]      w_grant;
  logic [c_idx_w-1:0]  w_idx;
  logic                w_any;
  logic [1:0]          w_sel_cmd;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [ADDR_W-1:0]   w_vid_addr;
  logic                w_acked;
  logic                w_tmo_hit;
  logic                w_sync_rise;
  logic                w_load;
  logic                w_accept;
  logic                w_timeout;

  // A request only counts when it carries a real command code
  for (genvar i = 0; i < NCH; i++) begin : g_valid
    assign w_valid[i] = req[i] && (ch_cmd[2*i +: 2] != CMD_NOP);
  end

  arb_pick #(
    .NCH   (NCH),
    .IDX_W (c_idx_w)
  ) u_pick (
    .i_valid (w_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_acked     = (sys_cmd_ack != 2'b00);
  assign w_tmo_hit   = (r_tmo_cnt == c_tmo_w'(ACK_TMO - 1));
  assign w_sync_rise = vid_sync && !r_sync_d;
  assign w_vid_addr  = ADDR_W'(VID_BASE) + ADDR_W'(vid_adr) * ADDR_W'(VID_STRIDE);

  always_comb begin
    w_sel_cmd  = ch_cmd[int'(w_idx)*2 +: 2];
    w_sel_addr = ch_addr[int'(w_idx)*ADDR_W +: ADDR_W];
    if (VID_EN != 0 && w_idx == '0) begin
      w_sel_addr = w_vid_addr;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_load      = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // an ack arriving on the last allowed cycle still wins
        if (w_acked) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_HOLD;
        end else if (w_tmo_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // let a stretched ack drain so it cannot accept the next command
        if (!w_acked) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sys_CMD    <= CMD_NOP;
      sys_ADDR   <= '0;
      ack_o      <= '0;
      data_owner <= '0;
      tmo_err    <= 1'b0;
      r_ptr      <= '0;
      r_win      <= '0;
      r_win_oh   <= '0;
      r_tmo_cnt  <= '0;
    end else begin
      ack_o <= '0;
      if (w_load) begin
        sys_CMD   <= w_sel_cmd;
        sys_ADDR  <= w_sel_addr;
        r_win     <= w_idx;
        r_win_oh  <= w_grant;
        r_tmo_cnt <= '0;
      end
      if (r_state == ST_ISSUE) begin
        r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
      end
      if (w_accept) begin
        sys_CMD    <= CMD_NOP;
        ack_o      <= r_win_oh;
        data_owner <= r_win_oh;
        if (RR_MODE != 0) begin
          r_ptr <= (r_win == c_idx_w'(NCH - 1)) ? '0 : r_win + c_idx_w'(1);
        end
      end
      if (w_timeout) begin
        sys_CMD <= CMD_NOP;
        tmo_err <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------ video counter
  // Advances while ack_o[0] is high, i.e. one cycle after acceptance; this
  // always lands before the next IDLE pick reads it. Sync edge overrides.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vid_adr  <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync_d <= vid_sync;
      if (w_sync_rise) begin
        vid_adr <= '0;
      end else if (VID_EN != 0 && ack_o[0]) begin
        vid_adr <= (vid_adr == c_va_w'(VID_WORDS - 1)) ? '0 : vid_adr + c_va_w'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_cmd_arbiter
// Description : Self-checking bench for sdram_cmd_arbiter. Instance 0 runs in
//               fixed-priority mode, instance 1 in round-robin mode; both have
//               the video channel enabled. A transaction-level model predicts
//               winner, command, address, ownership and video index.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_cmd_arbiter;

  localparam int VW    = 3072;
  localparam int VBASE = 'h37FC0;
  localparam int VSTR  = 8;
  localparam int TMO   = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req      [2];
  logic [5:0]  ch_cmd   [2];
  logic [53:0] ch_addr  [2];
  logic        vid_sync [2];
  logic [1:0]  ack      [2];
  logic [1:0]  sys_cmd  [2];
  logic [17:0] sys_addr [2];
  logic [2:0]  ack_o    [2];
  logic [2:0]  owner    [2];
  logic [11:0] vid_adr  [2];
  logic        tmo_err  [2];

  int checks   = 0;
  int failures = 0;

  // transaction-level model state
  int         ptr_m [2];
  int         vid_m [2];
  logic [2:0] own_m [2];
  logic       tmo_m [2];

  always #5 clk = ~clk;

  sdram_cmd_arbiter #(.RR_MODE(0)) u_fix (
    .clk(clk), .rst(rst), .req(req[0]), .ch_cmd(ch_cmd[0]), .ch_addr(ch_addr[0]),
    .vid_sync(vid_sync[0]), .sys_CMD(sys_cmd[0]), .sys_ADDR(sys_addr[0]),
    .sys_cmd_ack(ack[0]), .ack_o(ack_o[0]), .data_owner(owner[0]),
    .vid_adr(vid_adr[0]), .tmo_err(tmo_err[0])
  );

  sdram_cmd_arbiter #(.RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req(req[1]), .ch_cmd(ch_cmd[1]), .ch_addr(ch_addr[1]),
    .vid_sync(vid_sync[1]), .sys_CMD(sys_cmd[1]), .sys_ADDR(sys_addr[1]),
    .sys_cmd_ack(ack[1]), .ack_o(ack_o[1]), .data_owner(owner[1]),
    .vid_adr(vid_adr[1]), .tmo_err(tmo_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      ptr_m[m] = 0;
      vid_m[m] = 0;
      own_m[m] = '0;
      tmo_m[m] = 1'b0;
    end
  endtask

  // winner: first valid channel scanning from ptr (RR) or from 0 (fixed)
  function automatic int model_pick(input int m);
    int idx;
    for (int k = 0; k < 3; k++) begin
      idx = (m == 1) ? (ptr_m[m] + k) % 3 : k;
      if (req[m][idx] && ch_cmd[m][2*idx +: 2] != 2'b00) return idx;
    end
    return -1;
  endfunction

  function automatic logic [17:0] model_addr(input int m, input int w);
    if (w == 0) return 18'(VBASE + vid_m[m] * VSTR);
    return ch_addr[m][18*w +: 18];
  endfunction

  // One full transaction on instance m. Called at a negedge with the DUT idle
  // and the request vector already set up.
  task automatic txn(input int m, input int dly, input int ack_len,
                     input bit keep, input bit sync_on_ack, output int w);
    int         lat;
    logic [1:0] ecmd;
    logic [17:0] eaddr;
    logic [2:0] oh;
    w = model_pick(m);
    if (w < 0) return;
    ecmd  = ch_cmd[m][2*w +: 2];
    eaddr = model_addr(m, w);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (sys_cmd[m] == 2'b00 && lat < 8);
    chk("issue_latency", lat, 1);
    chk("sys_cmd", sys_cmd[m], ecmd);
    chk("sys_addr", sys_addr[m], eaddr);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("cmd_stable", sys_cmd[m], ecmd);
      chk("addr_stable", sys_addr[m], eaddr);
      chk("ack_o_idle", ack_o[m], 0);
    end
    ack[m] = 2'($urandom_range(1, 3));
    @(negedge clk);
    oh = 3'b001 << w;
    chk("ack_o", ack_o[m], oh);
    chk("data_owner", owner[m], oh);
    chk("cmd_cleared", sys_cmd[m], 0);
    own_m[m] = oh;
    if (!keep) req[m][w] = 1'b0;
    if (m == 1) ptr_m[m] = (w + 1) % 3;
    if (sync_on_ack) vid_m[m] = 0;
    else if (w == 0) vid_m[m] = (vid_m[m] + 1) % VW;
    if (sync_on_ack) vid_sync[m] = 1'b1;
    for (int i = 1; i < ack_len; i++) begin
      @(negedge clk);
      vid_sync[m] = 1'b0;
      chk("hold_no_reissue", sys_cmd[m], 0);
      chk("ack_o_pulse", ack_o[m], 0);
    end
    ack[m] = 2'b00;
    @(negedge clk);
    vid_sync[m] = 1'b0;
    chk("vid_adr", vid_adr[m], vid_m[m]);
    chk("data_owner_kept", owner[m], own_m[m]);
    chk("tmo_err", tmo_err[m], tmo_m[m]);
  endtask

  task automatic rand_phase(input int m, input int n);
    int w;
    int f;
    for (int t = 0; t < n; t++) begin
      for (int c = 0; c < 3; c++) begin
        // a pending valid request must be held unchanged until served
        if (!(req[m][c] && ch_cmd[m][2*c +: 2] != 2'b00)) begin
          req[m][c]          = 1'($urandom_range(0, 1));
          ch_cmd[m][2*c +: 2] = 2'($urandom_range(0, 3));
          ch_addr[m][18*c +: 18] = 18'($urandom);
        end
      end
      if (model_pick(m) < 0) begin
        f = $urandom_range(0, 2);
        req[m][f] = 1'b1;
        ch_cmd[m][2*f +: 2] = 2'($urandom_range(1, 3));
      end
      txn(m, $urandom_range(0, 4), $urandom_range(1, 3), 1'b0, 1'b0, w);
    end
    req[m] = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    int bad_ack;
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      req[m] = '0; ch_cmd[m] = '0; ch_addr[m] = '0; vid_sync[m] = 1'b0; ack[m] = 2'b00;
    end
    model_reset();
    repeat (3) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("rst_sys_cmd", sys_cmd[m], 0);
      chk("rst_sys_addr", sys_addr[m], 0);
      chk("rst_ack_o", ack_o[m], 0);
      chk("rst_owner", owner[m], 0);
      chk("rst_vid_adr", vid_adr[m], 0);
      chk("rst_tmo_err", tmo_err[m], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // fixed priority: ch1 (wr) beats ch2 (rd), then ch2 follows
    ch_cmd[0]  = {2'b11, 2'b01, 2'b00};
    ch_addr[0] = {18'h2ABCD, 18'h01234, 18'h00000};
    req[0]     = 3'b110;
    txn(0, 1, 1, 1'b0, 1'b0, w);
    chk("fix_first_owner", owner[0], 3'b010);
    txn(0, 2, 2, 1'b0, 1'b0, w);
    chk("fix_second_owner", owner[0], 3'b100);

    // round robin: everyone requests continuously, ack after 2 cycles
    ch_cmd[1]  = {2'b11, 2'b10, 2'b01};
    ch_addr[1] = {18'h3C001, 18'h10F00, 18'h00055};
    req[1]     = 3'b111;
    for (int i = 0; i < 6; i++) begin
      txn(1, 2, 1, 1'b1, 1'b0, w);
      chk("rr_order", owner[1], 3'b001 << (i % 3));
    end
    req[1] = '0;

    // ack timeout on ch2; pointer must stay put afterwards
    ch_cmd[1][5:4] = 2'b10;
    req[1] = 3'b100;
    n = 0;
    bad_ack = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sys_cmd[1] != 2'b00) n++;
      else if (n > 0) break;
      if (ack_o[1] != 3'b000) bad_ack++;
    end
    tmo_m[1] = 1'b1;
    chk("tmo_cycles", n, TMO);
    chk("tmo_err_set", tmo_err[1], 1);
    chk("tmo_no_ack", bad_ack, 0);
    chk("tmo_ack_o", ack_o[1], 0);
    chk("tmo_owner_kept", owner[1], own_m[1]);
    req[1] = '0;
    @(negedge clk);
    req[1] = 3'b111;
    txn(1, 1, 1, 1'b0, 1'b0, w);
    chk("tmo_ptr_kept", owner[1], 3'b001);
    req[1] = '0;

    // video: a full frame of ch0 bursts wraps the index back to 0
    ch_cmd[0] = {2'b00, 2'b00, 2'b10};
    ch_addr[0] = {36'h0, 18'h15555};
    req[0] = 3'b001;
    for (int i = 0; i < VW; i++) txn(0, 0, 1, 1'b1, 1'b0, w);
    chk("vid_wrapped", vid_adr[0], 0);
    for (int i = 0; i < 5; i++) txn(0, 0, 1, 1'b1, 1'b0, w);
    chk("vid_at_5", vid_adr[0], 5);
    txn(0, 0, 1, 1'b1, 1'b1, w);
    chk("vid_sync_wins", vid_adr[0], 0);
    txn(0, 1, 1, 1'b0, 1'b0, w);

    // randomized traffic on both instances
    rand_phase(0, 40);
    rand_phase(1, 40);

    // async reset in the middle of ISSUE
    chk("tmo_sticky", tmo_err[1], 1);
    ch_cmd[1][3:2] = 2'b10;
    req[1] = 3'b010;
    @(negedge clk);
    chk("pre_rst_issue", sys_cmd[1], 2'b10);
    #1 rst = 1'b1;
    #1;
    chk("arst_sys_cmd", sys_cmd[1], 0);
    chk("arst_ack_o", ack_o[1], 0);
    chk("arst_owner", owner[1], 0);
    chk("arst_tmo_err", tmo_err[1], 0);
    chk("arst_vid_adr", vid_adr[0], 0);
    req[0] = '0;
    req[1] = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ch_cmd[1][5:4] = 2'b11;
    req[1] = 3'b100;
    txn(1, 1, 1, 1'b0, 1'b0, w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
